// File: rtl/axi_lite_sram_lsu.sv
// axi_lite_sram_lsu: AXI4-Lite slave word memory for the LSU data path.
// One transaction in flight; read/write collisions in IDLE are arbitrated by a
// toggling priority bit. Access latency is fixed at READ_LAT/WRITE_LAT, or
// stretched by 0..7 pseudo-random cycles when AXI_SRAM_RAND_LAT_EN is defined.
module axi_lite_sram_lsu #(
    parameter int unsigned           ADDR_W    = 32,
    parameter int unsigned           DATA_W    = 32,
    parameter int unsigned           MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int unsigned           READ_LAT  = 2,
    parameter int unsigned           WRITE_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(STRB_W);
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam int unsigned MEM_BYTES = MEM_WORDS * STRB_W;
    localparam int unsigned MAX_LAT   = ((READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT) + 8;
    localparam int unsigned CNT_W     = $clog2(MAX_LAT + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT    = 3'd1,
        RD_RESP    = 3'd2,
        WR_COLLECT = 3'd3,
        WR_WAIT    = 3'd4,
        WR_RESP    = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                prio;
    logic [CNT_W-1:0]    cnt;
    logic                aw_got;
    logic                w_got;
    logic [2:0]          extra;

    logic [ADDR_W-1:0]   araddr_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic [DATA_W-1:0]   mem [MEM_WORDS];

    logic                collide;
    logic                ar_hs;
    logic                aw_hs;
    logic                w_hs;
    logic                cnt_zero;

    logic [ADDR_W-1:0]   rd_off;
    logic [ADDR_W-1:0]   wr_off;
    logic                rd_ok;
    logic                wr_ok;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;

    assign collide  = arvalid & (awvalid | wvalid);
    assign ar_hs    = arvalid & arready;
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign cnt_zero = (cnt == '0);

    // Address decode relative to BASE_ADDR; sub-word offset bits are ignored.
    assign rd_off = araddr_q - BASE_ADDR;
    assign wr_off = awaddr_q - BASE_ADDR;
    assign rd_ok  = (araddr_q >= BASE_ADDR) && (rd_off < ADDR_W'(MEM_BYTES));
    assign wr_ok  = (awaddr_q >= BASE_ADDR) && (wr_off < ADDR_W'(MEM_BYTES));
    assign rd_idx = rd_off[OFF_W +: IDX_W];
    assign wr_idx = wr_off[OFF_W +: IDX_W];

`ifdef AXI_SRAM_RAND_LAT_EN
    logic [7:0] lfsr;
    logic [2:0] extra_q;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; extra latency is latched at the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= 8'hA5;
            extra_q <= 3'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == IDLE) begin
                extra_q <= lfsr[2:0];
            end
        end
    end

    assign extra = (state == IDLE) ? lfsr[2:0] : extra_q;
`else
    assign extra = 3'd0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    state_next = RD_WAIT;
                end else if (aw_hs && w_hs) begin
                    state_next = WR_WAIT;
                end else if (aw_hs || w_hs) begin
                    state_next = WR_COLLECT;
                end
            end
            WR_COLLECT: begin
                if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                    state_next = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_zero) begin
                    state_next = RD_RESP;
                end
            end
            WR_WAIT: begin
                if (cnt_zero) begin
                    state_next = WR_RESP;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    state_next = IDLE;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Channel readies and response valids; the losing channel of a collision sees ready low.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        bvalid  = 1'b0;
        case (state)
            IDLE: begin
                arready = !(collide && prio);
                awready = !(collide && !prio);
                wready  = !(collide && !prio);
            end
            WR_COLLECT: begin
                awready = !aw_got;
                wready  = !w_got;
            end
            RD_RESP: rvalid = 1'b1;
            WR_RESP: bvalid = 1'b1;
            default: ;
        endcase
    end

    // Arbitration priority, write-channel collection flags and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio   <= 1'b0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && collide) begin
                prio <= !prio;
            end
            if (state_next == WR_COLLECT) begin
                aw_got <= aw_got | aw_hs;
                w_got  <= w_got | w_hs;
            end else begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (state != RD_WAIT && state_next == RD_WAIT) begin
                cnt <= CNT_W'(READ_LAT - 1) + CNT_W'(extra);
            end else if (state != WR_WAIT && state_next == WR_WAIT) begin
                cnt <= CNT_W'(WRITE_LAT - 1) + CNT_W'(extra);
            end else if (!cnt_zero) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Capture address/data on every handshake.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            araddr_q <= araddr;
        end
        if (aw_hs) begin
            awaddr_q <= awaddr;
        end
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Response registers, loaded on the edge entering the response state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
            bresp <= RESP_OKAY;
        end else begin
            if (state == RD_WAIT && cnt_zero) begin
                rdata <= rd_ok ? mem[rd_idx] : '0;
                rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (state == WR_WAIT && cnt_zero) begin
                bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Byte-strobed array write, committed before BVALID is raised; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && state == WR_WAIT && cnt_zero && wr_ok) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_lsu.sv
// Scoreboard bench for axi_lite_sram_lsu: drivers push expected responses,
// a negedge monitor pops and compares data, response code and latency.
module tb_axi_lite_sram_lsu;

    localparam int RL = 2;
    localparam int WL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    axi_lite_sram_lsu dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          hs_cyc;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Monitor: pops an expectation whenever a new response appears, checks hold while stalled.
    logic        rv_prev = 1'b0;
    logic        rr_prev = 1'b0;
    logic [31:0] r_held  = '0;
    logic [1:0]  rr_held = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rv_prev = 1'b0;
            rr_prev = 1'b0;
        end else begin
            if (rv_prev && !rr_prev) begin
                chk("rvalid_hold", rvalid, 1);
                chk("rdata_hold", rdata, r_held);
                chk("rresp_hold", rresp, rr_held);
            end else if (rvalid) begin
                if (rd_q.size() == 0) begin
                    timeout("unexpected_rvalid");
                end else begin
                    e = rd_q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", rresp, e.resp);
                    chk("read_latency", cyc - e.hs_cyc, RL);
                end
                r_held  = rdata;
                rr_held = rresp;
            end
            if (bvalid) begin
                if (wr_q.size() == 0) begin
                    timeout("unexpected_bvalid");
                end else begin
                    e = wr_q.pop_front();
                    chk("bresp", bresp, e.resp);
                    chk("write_latency", cyc - e.hs_cyc, WL);
                end
            end
            rv_prev = rvalid;
            rr_prev = rready;
        end
    end

    // Read address driver; pushes the hand-computed expected response at the AR handshake.
    task automatic drive_rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        logic hs;
        exp_t e;
        araddr  = a;
        arvalid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            hs = arvalid & arready;
            @(posedge clk);
            #1;
            if (hs) begin
                arvalid  = 1'b0;
                e.data   = ed;
                e.resp   = er;
                e.hs_cyc = cyc;
                rd_q.push_back(e);
                return;
            end
        end
        arvalid = 1'b0;
        timeout("ar_handshake");
    endtask

    // Write driver; optionally presents W one cycle ahead of AW.
    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input bit w_lead);
        logic ahs, whs;
        bit aw_done, w_done;
        exp_t e;
        aw_done = 0;
        w_done  = 0;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        awvalid = !w_lead;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (aw_done != w_done) begin
                chk("collect_awready", awready, aw_done ? 0 : 1);
                chk("collect_wready", wready, w_done ? 0 : 1);
            end
            ahs = awvalid & awready;
            whs = wvalid & wready;
            @(posedge clk);
            #1;
            if (ahs) begin
                aw_done = 1;
                awvalid = 1'b0;
            end
            if (whs) begin
                w_done = 1;
                wvalid = 1'b0;
            end
            if (w_lead && !aw_done) awvalid = 1'b1;
            if (aw_done && w_done) begin
                e.data   = '0;
                e.resp   = er;
                e.hs_cyc = cyc;
                wr_q.push_back(e);
                return;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        timeout("aw_w_handshake");
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_q.size() == 0 && wr_q.size() == 0) break;
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        @(posedge clk);
        #1;

        // Basic write then read back
        drive_wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
        wait_done();
        drive_rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        wait_done();

        // Byte strobes, and an all-zero strobe leaving the word unchanged
        drive_wr(32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 0);
        wait_done();
        drive_wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 0);
        wait_done();
        drive_rd(32'h8000_0020, 32'h11BB_33DD, 2'b00);
        wait_done();
        drive_wr(32'h8000_0022, 32'hFFFF_FFFF, 4'h0, 2'b00, 0);
        wait_done();
        drive_rd(32'h8000_0023, 32'h11BB_33DD, 2'b00);
        wait_done();

        // W ahead of AW, then a read stalled by rready for 5 cycles
        drive_wr(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 2'b00, 1);
        wait_done();
        rready = 1'b0;
        drive_rd(32'h8000_0030, 32'hCAFE_F00D, 2'b00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) break;
        end
        repeat (5) @(posedge clk);
        #1 rready = 1'b1;
        wait_done();

        // Collision: read wins first, write wins on the repeat
        fork
            drive_rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
            drive_wr(32'h8000_0010, 32'h0102_0304, 4'hF, 2'b00, 0);
            begin
                @(negedge clk);
                chk("col1_arready", arready, 1);
                chk("col1_awready", awready, 0);
                chk("col1_wready", wready, 0);
            end
        join
        wait_done();
        fork
            drive_rd(32'h8000_0010, 32'h0A0B_0C0D, 2'b00);
            drive_wr(32'h8000_0010, 32'h0A0B_0C0D, 4'hF, 2'b00, 0);
            begin
                @(negedge clk);
                chk("col2_arready", arready, 0);
                chk("col2_awready", awready, 1);
                chk("col2_wready", wready, 1);
            end
        join
        wait_done();

        // Out-of-range accesses: SLVERR, zero data, array untouched
        drive_wr(32'h8000_0000, 32'h5A5A_5A5A, 4'hF, 2'b00, 0);
        wait_done();
        drive_wr(32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 2'b00, 0);
        wait_done();
        drive_rd(32'h7FFF_FFFC, 32'h0000_0000, 2'b10);
        wait_done();
        drive_rd(32'h8000_1000, 32'h0000_0000, 2'b10);
        wait_done();
        drive_wr(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        wait_done();
        drive_wr(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        wait_done();
        drive_rd(32'h8000_0000, 32'h5A5A_5A5A, 2'b00);
        wait_done();
        drive_rd(32'h8000_0FFC, 32'hA5A5_A5A5, 2'b00);
        wait_done();

        // Reset while a read is waiting aborts it; memory keeps its contents
        araddr  = 32'h8000_0020;
        arvalid = 1'b1;
        @(negedge clk);
        chk("abort_arready", arready, 1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_rvalid", rvalid, 0);
            chk("abort_arready_idle", arready, 1);
        end
        @(posedge clk);
        #1;
        drive_rd(32'h8000_0020, 32'h11BB_33DD, 2'b00);
        wait_done();

        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
